reduction_scheduler: RTL and testbench

- Shares one 6-function reduction unit (AND, NAND, OR, NOR, XOR, XNOR over a W-bit word) among N requesters.
- Round-robin arbitration picks one requester at a time; the block latches its operand and opcode, computes the reduction and returns a tagged result over a valid/ready response port.
- Sits between several client blocks and the shared reduction datapath.
- Keeps a running count of completed operations.

---
 rtl/reduction_scheduler.sv | 135 +++++++++++++
 tb/tb_reduction_scheduler.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/reduction_scheduler.sv
// Round-robin scheduler that shares one 6-function bitwise reduction unit among N requesters.
// Each accepted request goes through IDLE -> EXEC -> RESP and gets one tagged response over valid/ready.
module reduction_scheduler #(
  parameter int N   = 4,
  parameter int W   = 8,
  parameter int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_valid,
  output logic [N-1:0]   req_ready,
  input  logic [N*W-1:0] req_data,
  input  logic [N*3-1:0] req_op,
  output logic           resp_valid,
  input  logic           resp_ready,
  output logic [IDW-1:0] resp_id,
  output logic           resp_result,
  output logic           resp_err,
  output logic           busy,
  output logic [15:0]    done_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] ptr_nxt;
  logic [IDW-1:0] winner;
  logic [IDW-1:0] idx;
  logic           any_req;
  logic [W-1:0]   lat_data;
  logic [2:0]     lat_op;

  // Returns {err, result}; opcodes 6 and 7 are illegal and force result to 0.
  function automatic logic [1:0] reduce(input logic [W-1:0] d, input logic [2:0] op);
    logic [1:0] r;
    r = 2'b00;
    case (op)
      3'd0:    r = {1'b0,  &d};
      3'd1:    r = {1'b0, ~&d};
      3'd2:    r = {1'b0,  |d};
      3'd3:    r = {1'b0, ~|d};
      3'd4:    r = {1'b0,  ^d};
      3'd5:    r = {1'b0, ~^d};
      default: r = 2'b10;
    endcase
    return r;
  endfunction

  // Rotating priority search starting at ptr; the first valid requester wins.
  always_comb begin
    any_req = 1'b0;
    winner  = '0;
    idx     = '0;
    for (int unsigned i = 0; i < int'(N); i++) begin
      idx = IDW'((32'(ptr) + i) % 32'(N));
      if (!any_req && req_valid[idx]) begin
        any_req = 1'b1;
        winner  = idx;
      end
    end
  end

  always_comb begin
    ptr_nxt = (winner == IDW'(N - 1)) ? '0 : winner + 1'b1;
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && any_req && !rst) begin
      req_ready[winner] = 1'b1;
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr         <= '0;
      lat_data    <= '0;
      lat_op      <= '0;
      resp_valid  <= 1'b0;
      resp_id     <= '0;
      resp_result <= 1'b0;
      resp_err    <= 1'b0;
      done_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            lat_data <= req_data[winner*W +: W];
            lat_op   <= req_op[winner*3 +: 3];
            resp_id  <= winner;
            ptr      <= ptr_nxt;
          end
        end
        EXEC: begin
          {resp_err, resp_result} <= reduce(lat_data, lat_op);
          resp_valid              <= 1'b1;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            done_count <= done_count + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reduction_scheduler.sv
// Directed bench for reduction_scheduler: opcodes, arbitration order, backpressure and reset.
module tb_reduction_scheduler;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int IDW = 2;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_data;
  logic [N*3-1:0] req_op;
  logic           resp_valid;
  logic           resp_ready;
  logic [IDW-1:0] resp_id;
  logic           resp_result;
  logic           resp_err;
  logic           busy;
  logic [15:0]    done_count;

  int          total;
  int          bad;
  logic [15:0] exp_dc;

  reduction_scheduler #(.N(N), .W(W), .IDW(IDW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_data    (req_data),
    .req_op      (req_op),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_id     (resp_id),
    .resp_result (resp_result),
    .resp_err    (resp_err),
    .busy        (busy),
    .done_count  (done_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Single-requester transaction; entered and left at a negedge in IDLE with resp_ready=1.
  task automatic do_txn(input int who, input logic [7:0] d, input logic [2:0] op,
                        input logic [7:0] d_after, input logic exp_res, input logic exp_err);
    req_valid = 4'b0001 << who;
    req_data[who*8 +: 8] = d;
    req_op[who*3 +: 3]   = op;
    #1;
    chk("idle_ready", req_ready, 4'b0001 << who);
    @(negedge clk);
    req_valid = '0;
    req_data[who*8 +: 8] = d_after;
    #1;
    chk("exec_ready", req_ready, 0);
    chk("exec_valid", resp_valid, 0);
    chk("exec_busy", busy, 1);
    @(negedge clk);
    chk("resp_valid", resp_valid, 1);
    chk("resp_id", resp_id, who);
    chk("resp_result", resp_result, exp_res);
    chk("resp_err", resp_err, exp_err);
    @(negedge clk);
    exp_dc++;
    chk("done_valid", resp_valid, 0);
    chk("done_busy", busy, 0);
    chk("done_count", done_count, exp_dc);
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    exp_dc     = '0;
    rst        = 1'b1;
    req_valid  = 4'hF;
    req_data   = '0;
    req_op     = '0;
    resp_ready = 1'b1;

    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", req_ready, 0);
    chk("rst_valid", resp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_id", resp_id, 0);
    chk("rst_count", done_count, 0);

    // Everyone requests continuously: grants rotate 0,1,2,3,0.
    rst = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("rr_grant", req_ready, 4'b0001 << (k % 4));
      @(negedge clk);
      chk("rr_exec_ready", req_ready, 0);
      @(negedge clk);
      chk("rr_resp_ready", req_ready, 0);
      chk("rr_valid", resp_valid, 1);
      chk("rr_id", resp_id, k % 4);
      chk("rr_result", resp_result, 0);
      @(negedge clk);
      exp_dc++;
      chk("rr_count", done_count, exp_dc);
    end
    req_valid = '0;

    // All opcodes on 8'hFF from requester 2.
    do_txn(2, 8'hFF, 3'd0, 8'hFF, 1'b1, 1'b0);
    do_txn(2, 8'hFF, 3'd1, 8'hFF, 1'b0, 1'b0);
    do_txn(2, 8'hFF, 3'd2, 8'hFF, 1'b1, 1'b0);
    do_txn(2, 8'hFF, 3'd3, 8'hFF, 1'b0, 1'b0);
    do_txn(2, 8'hFF, 3'd4, 8'hFF, 1'b0, 1'b0);
    do_txn(2, 8'hFF, 3'd5, 8'hFF, 1'b1, 1'b0);

    // Parity, zero word and illegal opcodes.
    do_txn(2, 8'h07, 3'd4, 8'h07, 1'b1, 1'b0);
    do_txn(3, 8'h00, 3'd3, 8'h00, 1'b1, 1'b0);
    do_txn(3, 8'h00, 3'd6, 8'h00, 1'b0, 1'b1);
    do_txn(0, 8'hFF, 3'd7, 8'hFF, 1'b0, 1'b1);
    do_txn(1, 8'h3C, 3'd2, 8'h3C, 1'b1, 1'b0);

    // Operand changed after accept must not affect the result.
    do_txn(1, 8'hF0, 3'd4, 8'hFF, 1'b0, 1'b0);

    // Backpressure: hold RESP for 5 cycles while requester 1 waits.
    resp_ready = 1'b0;
    req_valid  = 4'b0001;
    req_data[0 +: 8] = 8'hA5;
    req_op[0 +: 3]   = 3'd5;
    #1;
    chk("bp_accept", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = 4'b0010;
    @(negedge clk);
    repeat (5) begin
      chk("bp_valid", resp_valid, 1);
      chk("bp_result", resp_result, 1);
      chk("bp_id", resp_id, 0);
      chk("bp_ready", req_ready, 0);
      chk("bp_count", done_count, exp_dc);
      chk("bp_busy", busy, 1);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    exp_dc++;
    chk("bp_release_valid", resp_valid, 0);
    chk("bp_release_busy", busy, 0);
    chk("bp_release_count", done_count, exp_dc);
    chk("bp_next_grant", req_ready, 4'b0010);
    req_valid = '0;

    // Reset while in RESP discards the response and rewinds the pointer.
    resp_ready = 1'b0;
    req_valid  = 4'b0001;
    req_data[0 +: 8] = 8'hFF;
    req_op[0 +: 3]   = 3'd0;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    chk("mr_resp_valid", resp_valid, 1);
    rst       = 1'b1;
    req_valid = 4'b1010;
    @(negedge clk);
    chk("mr_valid", resp_valid, 0);
    chk("mr_busy", busy, 0);
    chk("mr_count", done_count, 0);
    chk("mr_ready", req_ready, 0);
    exp_dc = '0;
    rst    = 1'b0;
    resp_ready = 1'b1;
    #1;
    chk("mr_grant", req_ready, 4'b0010);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    chk("mr_resp", resp_valid, 1);
    chk("mr_id", resp_id, 1);
    @(negedge clk);
    exp_dc++;
    chk("mr_done", done_count, exp_dc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
